// File: rtl/port_wr_ingress_queue.sv
// Per-port write-ingress buffer: circular half-word store plus a descriptor queue
// that feeds the SRAM matcher and forwards matched packets cut-through to the backend.
module port_wr_ingress_queue #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 64,
    parameter int PKT_Q        = 4,
    parameter int PORT_W       = 4,
    parameter int LEN_W        = 9,
    parameter int PAUSE_MARGIN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_sop,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_eop,
    output logic              pause,
    output logic              match_enable,
    output logic [PORT_W-1:0] new_dest_port,
    output logic [LEN_W-1:0]  new_length,
    input  logic              match_suc,
    output logic              ready_to_xfer,
    output logic              xfer_data_vld,
    output logic [DATA_W-1:0] xfer_data,
    output logic              end_of_packet,
    output logic              len_err,
    output logic              ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(PKT_Q);
    localparam int CW = LEN_W + 1;
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN   = (AW+1)'(PAUSE_MARGIN);
    localparam logic [QW:0] Q_FULL   = (QW+1)'(PKT_Q);

    typedef enum logic [1:0] {W_IDLE, W_HDR, W_BODY} wstate_t;
    typedef enum logic [1:0] {X_IDLE, X_RUN, X_STALL} xstate_t;

    wstate_t r_wstate, w_wstate_nx;
    xstate_t r_xstate, w_xstate_nx;

    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_occ;
    logic [QW:0]       r_wr_q, r_mt_q, r_rd_q;
    logic [PORT_W-1:0] r_dq_dest [PKT_Q];
    logic [LEN_W-1:0]  r_dq_len  [PKT_Q];
    logic [CW-1:0]     r_dq_wcnt [PKT_Q];
    logic              r_dq_done [PKT_Q];
    logic [CW-1:0]     r_xcnt;
    logic              r_pause, r_xfer_vld, r_eop, r_len_err, r_ovf_err;
    logic [DATA_W-1:0] r_xfer_data;

    logic              w_full, w_wr_active, w_wr_en, w_ovf;
    logic              w_q_full, w_hdr_push, w_body_wr, w_eop;
    logic [QW-1:0]     w_tail, w_mt_idx, w_rd_idx;
    logic [CW-1:0]     w_tail_wcnt;
    logic              w_match, w_cur_done, w_can_read, w_last, w_rd_en;
    logic [AW:0]       w_free;

    assign w_full      = (r_occ == OCC_FULL);
    assign w_free      = OCC_FULL - r_occ;
    assign w_wr_active = (r_wstate != W_IDLE) && wr_vld;
    assign w_wr_en     = w_wr_active && !w_full;
    assign w_ovf       = w_wr_active && w_full;
    assign w_q_full    = ((r_wr_q - r_rd_q) == Q_FULL);
    assign w_tail      = r_wr_q[QW-1:0] - QW'(1);
    assign w_mt_idx    = r_mt_q[QW-1:0];
    assign w_rd_idx    = r_rd_q[QW-1:0];
    assign w_hdr_push  = (r_wstate == W_HDR) && w_wr_en;
    assign w_body_wr   = (r_wstate == W_BODY) && w_wr_en;
    assign w_eop       = (r_wstate == W_BODY) && wr_eop;
    assign w_tail_wcnt = r_dq_wcnt[w_tail] + (w_body_wr ? CW'(1) : CW'(0));

    assign match_enable  = (r_mt_q != r_wr_q);
    assign new_dest_port = match_enable ? r_dq_dest[w_mt_idx] : '0;
    assign new_length    = match_enable ? (r_dq_len[w_mt_idx] - LEN_W'(1)) : '0;
    assign w_match       = match_suc && match_enable;
    assign ready_to_xfer = (r_xstate == X_IDLE) && (r_rd_q != r_mt_q);

    // An unfinished packet's newest word is held back until eop (or a later word)
    // shows whether it is the last one, so end_of_packet always rides on it.
    assign w_cur_done = r_dq_done[w_rd_idx];
    assign w_can_read = (r_occ != '0) && (w_cur_done || (r_occ > (AW+1)'(1)));
    assign w_last     = w_cur_done && ((r_xcnt + CW'(1)) == r_dq_wcnt[w_rd_idx]);

    always_comb begin
        w_wstate_nx = r_wstate;
        case (r_wstate)
            W_IDLE:  if (wr_sop && !w_q_full) w_wstate_nx = W_HDR;
            W_HDR:   if (w_hdr_push) w_wstate_nx = W_BODY;
            W_BODY:  if (wr_eop) w_wstate_nx = W_IDLE;
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    always_comb begin
        w_xstate_nx = r_xstate;
        w_rd_en     = 1'b0;
        case (r_xstate)
            X_IDLE:  if (ready_to_xfer) w_xstate_nx = X_RUN;
            X_RUN: begin
                if (w_can_read) begin
                    w_rd_en = 1'b1;
                    if (w_last) w_xstate_nx = X_IDLE;
                end else begin
                    w_xstate_nx = X_STALL;
                end
            end
            X_STALL: if (w_can_read) w_xstate_nx = X_RUN;
            default: w_xstate_nx = X_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_xstate <= X_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_wr_q   <= '0;
            r_mt_q   <= '0;
            r_rd_q   <= '0;
            r_xcnt   <= '0;
            for (int unsigned i = 0; i < PKT_Q; i++) begin
                r_dq_dest[i] <= '0;
                r_dq_len[i]  <= '0;
                r_dq_wcnt[i] <= '0;
                r_dq_done[i] <= 1'b0;
            end
        end else begin
            r_wstate <= w_wstate_nx;
            r_xstate <= w_xstate_nx;
            r_occ    <= r_occ + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_hdr_push) begin
                r_dq_dest[r_wr_q[QW-1:0]] <= wr_data[PORT_W-1:0];
                r_dq_len[r_wr_q[QW-1:0]]  <= wr_data[DATA_W-1:7];
                r_dq_wcnt[r_wr_q[QW-1:0]] <= CW'(1);
                r_dq_done[r_wr_q[QW-1:0]] <= 1'b0;
                r_wr_q <= r_wr_q + (QW+1)'(1);
            end
            if (w_body_wr) r_dq_wcnt[w_tail] <= w_tail_wcnt;
            if (w_eop) r_dq_done[w_tail] <= 1'b1;
            if (w_match) r_mt_q <= r_mt_q + (QW+1)'(1);
            if (r_xstate == X_IDLE) r_xcnt <= '0;
            else if (w_rd_en) r_xcnt <= r_xcnt + CW'(1);
            if (w_rd_en && w_last) r_rd_q <= r_rd_q + (QW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pause     <= 1'b0;
            r_xfer_vld  <= 1'b0;
            r_eop       <= 1'b0;
            r_len_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_xfer_data <= '0;
        end else begin
            r_pause    <= (w_free <= MARGIN) || w_q_full;
            r_xfer_vld <= w_rd_en;
            r_eop      <= w_rd_en && w_last;
            r_len_err  <= w_eop && (w_tail_wcnt != {1'b0, r_dq_len[w_tail]});
            r_ovf_err  <= w_ovf;
            if (w_rd_en) r_xfer_data <= r_buf[r_rd_ptr];
        end
    end

    assign pause         = r_pause;
    assign xfer_data_vld = r_xfer_vld;
    assign xfer_data     = r_xfer_data;
    assign end_of_packet = r_eop;
    assign len_err       = r_len_err;
    assign ovf_err       = r_ovf_err;
endmodule

// File: tb/tb_port_wr_ingress_queue.sv
// Directed bench for port_wr_ingress_queue: one task per scenario, hand-derived expectations.
module tb_port_wr_ingress_queue;
    logic        clk = 1'b0;
    logic        rst_n, wr_sop, wr_vld, wr_eop, match_suc;
    logic [15:0] wr_data;
    logic        pause, match_enable, ready_to_xfer, xfer_data_vld, end_of_packet, len_err, ovf_err;
    logic [3:0]  new_dest_port;
    logic [8:0]  new_length;
    logic [15:0] xfer_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_len = 0;
    int n_ovf = 0;
    logic [15:0] q_data[$];
    bit          q_eop[$];
    int          q_cyc[$];
    logic [15:0] exp_data[$];
    bit          exp_eop[$];

    always #5 clk = ~clk;

    port_wr_ingress_queue #(.DATA_W(16), .DEPTH(64), .PKT_Q(4), .PORT_W(4), .LEN_W(9),
                            .PAUSE_MARGIN(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_data(wr_data),
        .wr_eop(wr_eop), .pause(pause), .match_enable(match_enable),
        .new_dest_port(new_dest_port), .new_length(new_length), .match_suc(match_suc),
        .ready_to_xfer(ready_to_xfer), .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
        .end_of_packet(end_of_packet), .len_err(len_err), .ovf_err(ovf_err)
    );

    always @(negedge clk) begin
        cyc++;
        if (xfer_data_vld) begin
            q_data.push_back(xfer_data);
            q_eop.push_back(end_of_packet);
            q_cyc.push_back(cyc);
        end
        if (len_err) n_len++;
        if (ovf_err) n_ovf++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bw(input int id, input int i);
        return 16'hA000 | 16'((id & 15) << 8) | 16'(i & 255);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0; match_suc = 1'b0;
        wr_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        q_data.delete(); q_eop.delete(); q_cyc.delete();
        exp_data.delete(); exp_eop.delete();
        n_len = 0; n_ovf = 0;
    endtask

    task automatic send_word(input logic [15:0] d);
        wr_vld = 1'b1; wr_data = d;
        tick();
        wr_vld = 1'b0;
        exp_data.push_back(d);
        exp_eop.push_back(1'b0);
    endtask

    task automatic send_pkt(input int dest, input int len, input int nwords, input int id);
        wr_sop = 1'b1;
        tick();
        wr_sop = 1'b0;
        for (int i = 0; i < nwords; i++)
            send_word(i == 0 ? 16'((len << 7) | dest) : bw(id, i));
        exp_eop[exp_eop.size()-1] = 1'b1;
        wr_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q_data.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_sop = 1'b1; wr_vld = 1'b1; wr_eop = 1'b0; match_suc = 1'b1;
        wr_data = 16'h0405;
        tick(); tick();
        checks++;
        if ({pause, match_enable, ready_to_xfer, xfer_data_vld, end_of_packet, len_err, ovf_err,
             new_dest_port, new_length, xfer_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pause=%b me=%b rdy=%b vld=%b eop=%b le=%b oe=%b dst=%0h len=%0h dat=%0h exp all 0",
                     pause, match_enable, ready_to_xfer, xfer_data_vld, end_of_packet, len_err,
                     ovf_err, new_dest_port, new_length, xfer_data);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        wr_sop = 1'b1; tick(); wr_sop = 1'b0;
        checks++;
        if (match_enable !== 1'b0) begin
            errors++; $display("FAIL single_me_before_hdr got %b exp 0", match_enable);
        end
        send_word(16'h0405);
        checks++;
        if ({match_enable, new_dest_port, new_length} !== {1'b1, 4'd5, 9'd7}) begin
            errors++;
            $display("FAIL single_hdr_present got me=%b dst=%0d len=%0d exp me=1 dst=5 len=7",
                     match_enable, new_dest_port, new_length);
        end
        for (int i = 1; i < 8; i++) send_word(bw(1, i));
        exp_eop[7] = 1'b1;
        wr_eop = 1'b1; tick(); wr_eop = 1'b0;
        match_suc = 1'b1; tick(); match_suc = 1'b0;
        wait_out(8, ok);
        checks++;
        if (!ok || q_data.size() != 8) begin
            errors++; $display("FAIL single_count got %0d exp 8", q_data.size());
        end
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== exp_data[k] || q_eop[k] !== exp_eop[k]) begin
                errors++;
                $display("FAIL single_word%0d got %h/%b exp %h/%b", k, q_data[k], q_eop[k],
                         exp_data[k], exp_eop[k]);
            end
        end
        checks++;
        if ({match_enable, n_len} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL single_after got me=%b len_errs=%0d exp 0 0", match_enable, n_len);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        send_pkt(1, 3, 3, 1);
        send_pkt(2, 4, 4, 2);
        send_pkt(3, 2, 2, 3);
        repeat (3) tick();
        checks++;
        if ({match_enable, new_dest_port, new_length, ready_to_xfer} !== {1'b1, 4'd1, 9'd2, 1'b0} ||
            q_data.size() != 0) begin
            errors++;
            $display("FAIL b2b_oldest got me=%b dst=%0d len=%0d rdy=%b out=%0d exp 1 1 2 0 0",
                     match_enable, new_dest_port, new_length, ready_to_xfer, q_data.size());
        end
        match_suc = 1'b1; repeat (3) tick(); match_suc = 1'b0;
        wait_out(9, ok);
        checks++;
        if (!ok || q_data.size() != 9) begin
            errors++; $display("FAIL b2b_count got %0d exp 9", q_data.size());
        end
        for (int k = 0; k < 9 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== exp_data[k] || q_eop[k] !== exp_eop[k]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h/%b exp %h/%b", k, q_data[k], q_eop[k],
                         exp_data[k], exp_eop[k]);
            end
        end
        if (q_cyc.size() == 9) begin
            for (int k = 1; k < 9; k++) begin
                checks++;
                if (q_cyc[k] - q_cyc[k-1] != ((k == 3 || k == 7) ? 2 : 1)) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got %0d exp %0d", k, q_cyc[k] - q_cyc[k-1],
                             (k == 3 || k == 7) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_queue_full();
        bit ok;
        do_reset();
        for (int p = 1; p <= 4; p++) send_pkt(p, 2, 2, p);
        tick();
        checks++;
        if (pause !== 1'b1) begin
            errors++; $display("FAIL qfull_pause got %b exp 1", pause);
        end
        send_pkt(5, 2, 2, 5);
        void'(exp_data.pop_back()); void'(exp_data.pop_back());
        void'(exp_eop.pop_back()); void'(exp_eop.pop_back());
        checks++;
        if ({match_enable, new_dest_port, new_length} !== {1'b1, 4'd1, 9'd1}) begin
            errors++;
            $display("FAIL qfull_oldest got me=%b dst=%0d len=%0d exp 1 1 1",
                     match_enable, new_dest_port, new_length);
        end
        match_suc = 1'b1; repeat (4) tick(); match_suc = 1'b0;
        wait_out(8, ok);
        checks++;
        if (!ok || q_data.size() != 8) begin
            errors++; $display("FAIL qfull_count got %0d exp 8", q_data.size());
        end
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== exp_data[k] || q_eop[k] !== exp_eop[k]) begin
                errors++;
                $display("FAIL qfull_word%0d got %h/%b exp %h/%b", k, q_data[k], q_eop[k],
                         exp_data[k], exp_eop[k]);
            end
        end
        checks++;
        if ({match_enable, pause} !== 2'b00) begin
            errors++; $display("FAIL qfull_drained got me=%b pause=%b exp 0 0", match_enable, pause);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n5;
        do_reset();
        wr_sop = 1'b1; tick(); wr_sop = 1'b0;
        send_word(16'h0309);
        checks++;
        if ({match_enable, new_dest_port, new_length} !== {1'b1, 4'd9, 9'd5}) begin
            errors++;
            $display("FAIL stall_hdr got me=%b dst=%0d len=%0d exp 1 9 5",
                     match_enable, new_dest_port, new_length);
        end
        match_suc = 1'b1;
        send_word(bw(4, 1));
        match_suc = 1'b0;
        send_word(bw(4, 2));
        repeat (5) tick();
        n5 = q_data.size();
        repeat (5) tick();
        checks++;
        if (q_data.size() != n5 || n5 < 1 || n5 > 3) begin
            errors++; $display("FAIL stall_hold got %0d then %0d exp steady in 1..3", n5, q_data.size());
        end
        for (int i = 3; i < 6; i++) send_word(bw(4, i));
        exp_eop[5] = 1'b1;
        wr_eop = 1'b1; tick(); wr_eop = 1'b0;
        wait_out(6, ok);
        checks++;
        if (!ok || q_data.size() != 6) begin
            errors++; $display("FAIL stall_count got %0d exp 6", q_data.size());
        end
        for (int k = 0; k < 6 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== exp_data[k] || q_eop[k] !== exp_eop[k]) begin
                errors++;
                $display("FAIL stall_word%0d got %h/%b exp %h/%b", k, q_data[k], q_eop[k],
                         exp_data[k], exp_eop[k]);
            end
        end
    endtask

    task automatic test_len_err();
        bit ok;
        do_reset();
        send_pkt(2, 6, 4, 6);
        tick();
        checks++;
        if (n_len != 1) begin
            errors++; $display("FAIL lenerr_pulse got %0d exp 1", n_len);
        end
        match_suc = 1'b1; tick(); match_suc = 1'b0;
        wait_out(4, ok);
        checks++;
        if (!ok || q_data.size() != 4) begin
            errors++; $display("FAIL lenerr_count got %0d exp 4", q_data.size());
        end
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== exp_data[k] || q_eop[k] !== exp_eop[k]) begin
                errors++;
                $display("FAIL lenerr_word%0d got %h/%b exp %h/%b", k, q_data[k], q_eop[k],
                         exp_data[k], exp_eop[k]);
            end
        end
    endtask

    task automatic test_overflow_reset();
        bit seen;
        do_reset();
        wr_sop = 1'b1; tick(); wr_sop = 1'b0;
        send_word(16'h2007);
        for (int i = 1; i < 64; i++) send_word(bw(7, i));
        tick();
        checks++;
        if ({pause, n_ovf} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL ovf_full got pause=%b ovf=%0d exp 1 0", pause, n_ovf);
        end
        send_word(16'hBEEF);
        wr_eop = 1'b1; tick(); wr_eop = 1'b0;
        tick();
        checks++;
        if ({n_ovf, n_len} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL ovf_pulse got ovf=%0d len=%0d exp 1 0", n_ovf, n_len);
        end
        checks++;
        if ({new_dest_port, new_length} !== {4'd7, 9'd63}) begin
            errors++; $display("FAIL ovf_desc got dst=%0d len=%0d exp 7 63", new_dest_port, new_length);
        end
        match_suc = 1'b1; tick(); match_suc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (xfer_data_vld) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL ovf_xfer_start got no vld exp vld within 20 cycles");
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({pause, match_enable, ready_to_xfer, xfer_data_vld, end_of_packet, len_err, ovf_err,
             new_dest_port, new_length, xfer_data} !== '0) begin
            errors++;
            $display("FAIL midxfer_reset got pause=%b me=%b rdy=%b vld=%b eop=%b dat=%0h exp all 0",
                     pause, match_enable, ready_to_xfer, xfer_data_vld, end_of_packet, xfer_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_queue_full();
        test_stall();
        test_len_err();
        test_overflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
